// File: rtl/if_stage_pkg.sv
// if_stage_pkg -- shared definitions for the instruction-fetch stage.
//   InstAddrBus / InstDataBus : fetch address and instruction word widths
//   fetch_state_e             : fetch FSM state encodings
//   ICACHE_IDX_W / _TAG_W     : optional instruction cache geometry
package if_stage_pkg;

  localparam int InstAddrBus  = 32;
  localparam int InstDataBus  = 32;

  localparam int ICACHE_IDX_W = 6;
  localparam int ICACHE_TAG_W = 24;
  localparam int ICACHE_LINES = 1 << ICACHE_IDX_W;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstDataBus-1:0] inst_data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if -- byte-wide memory read port between the fetch stage and
// the memory arbiter.
//   mem_req_out  : byte read request (fetch -> arbiter)
//   mem_addr_out : byte address of the request (fetch -> arbiter)
//   mem_gnt_in   : grant for the current request (arbiter -> fetch)
//   mem_byte_in  : read data, one cycle after an accepted request
// Modports: master = fetch stage, slave = memory arbiter.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       mem_req_out;
  inst_addr_t mem_addr_out;
  logic       mem_gnt_in;
  logic [7:0] mem_byte_in;

  modport master (
    output mem_req_out,
    output mem_addr_out,
    input  mem_gnt_in,
    input  mem_byte_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_addr_out,
    output mem_gnt_in,
    output mem_byte_in
  );

endinterface

// File: rtl/if_stage_icache.sv
// icache -- 64-line direct-mapped instruction cache, one word per line.
// Only instantiated by if_stage when ICACHE_EN is defined.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset (clears valid bits)
//   lookup_idx, lookup_tag  : combinational lookup; hit / hit_data respond same cycle
//   fill_en, fill_idx,
//   fill_tag, fill_data     : write one line on the clock edge
module icache
  import if_stage_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [ICACHE_IDX_W-1:0] lookup_idx,
  input  logic [ICACHE_TAG_W-1:0] lookup_tag,
  output logic                    hit,
  output inst_data_t              hit_data,
  input  logic                    fill_en,
  input  logic [ICACHE_IDX_W-1:0] fill_idx,
  input  logic [ICACHE_TAG_W-1:0] fill_tag,
  input  inst_data_t              fill_data
);

  logic [ICACHE_LINES-1:0] line_valid;
  logic [ICACHE_TAG_W-1:0] tag_mem  [ICACHE_LINES];
  inst_data_t              data_mem [ICACHE_LINES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bit gates every hit.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

  assign hit      = line_valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
  assign hit_data = data_mem[lookup_idx];

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch over a byte-wide memory port.
// Fetches four bytes little-endian, presents the word to decode, holds it
// while stalled, and redirects on jump. Optional instruction cache is
// compiled in with `define ICACHE_EN.
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   rdy_in               : global ready, low freezes all state
//   stall_in             : hold the presented word
//   jump_in, jump_pc_in  : redirect request and target
//   bus                  : memory read port (if_stage_if.master)
//   valid_out, pc_out,
//   instru_out           : fetched word and its address for decode
//
// state | meaning
// IDLE  | just out of reset, start fetching next cycle
// FETCH | issuing byte requests / collecting bytes for the word at pc
// HOLD  | word presented on valid_out until decode takes it (stall_in=0)
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        jump_in,
  input  inst_addr_t  jump_pc_in,
  if_stage_if.master  bus,
  output logic        valid_out,
  output inst_addr_t  pc_out,
  output inst_data_t  instru_out
);

  fetch_state_e state, state_n;
  inst_addr_t   pc, pc_n;
  logic [1:0]   cnt, cnt_n;     // index of the next byte to request
  logic         pend, pend_n;   // a byte is arriving this cycle
  logic         last, last_n;   // byte 3 requested, waiting for it
  logic [23:0]  byte_buf, byte_buf_n;
  logic         valid_n;
  inst_addr_t   pc_out_n;
  inst_data_t   instru_n;
  logic [1:0]   cap_idx;
  logic         req;
  logic         hit;
  inst_data_t   hit_data;

`ifdef ICACHE_EN
  logic line_hit;
  logic fill_en;

  // No fill when the word is aborted by a redirect in its completing cycle.
  assign fill_en = rdy_in && (state == ST_FETCH) && pend && last && !jump_in;

  icache u_icache (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .lookup_idx (pc[ICACHE_IDX_W+1:2]),
    .lookup_tag (pc[InstAddrBus-1:ICACHE_IDX_W+2]),
    .hit        (line_hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_idx   (pc[ICACHE_IDX_W+1:2]),
    .fill_tag   (pc[InstAddrBus-1:ICACHE_IDX_W+2]),
    .fill_data  ({bus.mem_byte_in, byte_buf})
  );

  // A hit is only taken at the start of a word, before any byte traffic.
  assign hit = line_hit && (cnt == 2'd0) && !pend && !last;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign req              = (state == ST_FETCH) && !last && !hit;
  assign bus.mem_req_out  = req;
  assign bus.mem_addr_out = pc + {30'd0, cnt};
  assign cap_idx          = cnt - 2'd1;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    pend_n     = pend;
    last_n     = last;
    byte_buf_n = byte_buf;
    valid_n    = valid_out;
    pc_out_n   = pc_out;
    instru_n   = instru_out;

    case (state)
      ST_IDLE: state_n = ST_FETCH;

      ST_FETCH: begin
        if (hit) begin
          valid_n  = 1'b1;
          pc_out_n = pc;
          instru_n = hit_data;
          state_n  = ST_HOLD;
        end
        if (pend) begin
          if (last) begin
            instru_n = {bus.mem_byte_in, byte_buf};
            valid_n  = 1'b1;
            pc_out_n = pc;
            state_n  = ST_HOLD;
            pend_n   = 1'b0;
            last_n   = 1'b0;
            cnt_n    = 2'd0;
          end else begin
            case (cap_idx)
              2'd0:    byte_buf_n[7:0]   = bus.mem_byte_in;
              2'd1:    byte_buf_n[15:8]  = bus.mem_byte_in;
              default: byte_buf_n[23:16] = bus.mem_byte_in;
            endcase
          end
        end
        if (req) begin
          if (bus.mem_gnt_in) begin
            pend_n = 1'b1;
            cnt_n  = cnt + 2'd1;
            last_n = (cnt == 2'd3);
          end else begin
            // Lost grant mid-word: drop partial bytes, restart at byte 0.
            pend_n = 1'b0;
            cnt_n  = 2'd0;
          end
        end
      end

      ST_HOLD: begin
        if (!stall_in) begin
          state_n = ST_FETCH;
          pc_n    = pc + 32'd4;
          valid_n = 1'b0;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Redirect wins over everything, including a word completing now.
    if (jump_in) begin
      state_n  = ST_FETCH;
      pc_n     = jump_pc_in;
      valid_n  = 1'b0;
      pc_out_n = pc_out;
      instru_n = instru_out;
      cnt_n    = 2'd0;
      pend_n   = 1'b0;
      last_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      pc         <= '0;
      cnt        <= 2'd0;
      pend       <= 1'b0;
      last       <= 1'b0;
      byte_buf   <= '0;
      valid_out  <= 1'b0;
      pc_out     <= '0;
      instru_out <= '0;
    end else if (rdy_in) begin
      state      <= state_n;
      pc         <= pc_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      last       <= last_n;
      byte_buf   <= byte_buf_n;
      valid_out  <= valid_n;
      pc_out     <= pc_out_n;
      instru_out <= instru_n;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have clk_in, input, 1, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have rst_in, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have rdy_in, input, 1, global ready; low freezes every register.
REQ-004 SHALL have stall_in, input, 1, pipeline stall from control; the word presented to decode is held while high.
REQ-005 SHALL have jump_in, input, 1, redirect request from execute (taken branch/JAL/JALR).
REQ-006 SHALL have jump_pc_in, input, 32, redirect target byte address.
REQ-007 SHALL have mem_gnt_in, input, 1, memory-port grant from the memory arbiter.
REQ-008 SHALL have mem_req_out, output, 1, byte read request to the memory arbiter.
REQ-009 SHALL have mem_addr_out, output, 32, byte address of the current request.
REQ-010 SHALL have mem_byte_in, input, 8, read data returned one cycle after an accepted request.
REQ-011 SHALL have valid_out, output, 1, pc_out/instru_out hold a fetched word for decode.
REQ-012 SHALL have pc_out, output, 32, byte address of instru_out.
REQ-013 SHALL have instru_out, output, 32, fetched instruction word.

Function
REQ-014 SHALL implement states IDLE, FETCH, HOLD.
- IDLE -> FETCH the cycle after reset release.
- FETCH -> HOLD when the 4th byte is captured (or a cache hit occurs).
- HOLD -> FETCH at pc+4 in the cycle where valid_out=1 and stall_in=0.
REQ-015 SHALL, in FETCH, request one byte per cycle while mem_gnt_in=1: addresses pc, pc+1, pc+2, pc+3 in consecutive cycles, with a 2-bit byte counter.
REQ-016 SHALL assemble little-endian: byte k into instru bits [8k+7:8k].
REQ-017 SHALL assert valid_out in the cycle after byte 3 arrives; uncached latency is 5 cycles from the first request to valid_out.
REQ-018 SHALL, if mem_gnt_in drops mid-word, discard the partial bytes and restart at byte 0 when the grant returns.
REQ-019 SHALL hold pc_out, instru_out and valid_out stable while stall_in=1.
REQ-020 SHALL, when jump_in=1, give the redirect top priority:
- next cycle valid_out=0 and pc=jump_pc_in;
- state FETCH at byte 0;
- in-flight bytes discarded, including a word completing in the same cycle.
REQ-021 SHALL ignore stall_in while jump_in=1.
REQ-022 SHALL wrap the PC modulo 2^32 (0xFFFFFFFC+4=0).
REQ-023 SHALL, while rdy_in=0, hold all state and outputs unchanged.
REQ-024 SHALL drive mem_req_out=0 in IDLE and HOLD.

Reset
REQ-025 SHALL reset on rst_in=1 at a clock edge, regardless of rdy_in: pc=0, valid_out=0, instru_out=0, pc_out=0, mem_req_out=0, mem_addr_out=0, byte counter=0, state IDLE.
REQ-026 SHALL, on reset mid-fetch, abandon the fetch; the first post-reset request is to address 0.

Configuration
REQ-027 SHALL compile a 64-entry direct-mapped instruction cache only when ICACHE_EN is defined.
- Index pc[7:2], tag pc[31:8], one valid bit per line.
REQ-028 SHALL, with ICACHE_EN, handle a hit in FETCH by skipping memory entirely and asserting valid_out next cycle.
REQ-029 SHALL, with ICACHE_EN, fill the line when byte 3 arrives (miss path), with no fill on an aborted fetch.
REQ-030 SHALL, with ICACHE_EN, clear the valid bits only on reset.
REQ-031 SHALL, without ICACHE_EN, instantiate no cache storage; every fetch uses the byte path (REQ-015..018).

Structure
REQ-032 SHALL take the following from the shared define include: InstAddrBus, InstDataBus, the state encodings, and the ICACHE index/tag widths.
REQ-033 SHALL place the cache in one sub-module, icache, with a lookup port and a fill port, instantiated only under ICACHE_EN.

Verification
REQ-034 Reset, memory bytes 0x13,0x05,0x10,0x00 at address 0 -> first request at cycle 1 after release; valid_out=1, pc_out=0, instru_out=0x00100513 five cycles after the first request.
REQ-035 stall_in=1 for 3 cycles while valid -> pc_out/instru_out unchanged and no mem_req_out; stall released -> next request at address 4.
REQ-036 jump_in=1, jump_pc_in=0x1000 on the cycle byte 3 arrives -> that word never valid; next request at 0x1000; valid_out low until the 0x1000 word completes.
REQ-037 mem_gnt_in=0 after byte 1 for 2 cycles -> refetch starting at pc+0; correct word delivered.
REQ-038 ICACHE_EN, loop re-fetches 0x0 -> second fetch: no mem_req_out and valid_out one cycle after entering FETCH; without ICACHE_EN the re-fetch shows 5-cycle latency.
REQ-039 Reset asserted during byte 2 -> outputs at reset values next cycle; restart at address 0.
